// File: rtl/spectrum_bar_encoder.sv
// spectrum_bar_encoder: quantizes per-bin magnitudes to 18-segment levels with peak-hold/decay, updating bars once per frame
module spectrum_bar_encoder #(
  parameter int MAG_W = 16,
  parameter int SHIFT = 11,
  parameter int DECAY_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mag_valid,
  output logic             mag_ready,
  input  logic [3:0]       mag_bin,
  input  logic [MAG_W-1:0] mag_data,
  input  logic             vsync,
  output logic [17:0]      bar0,
  output logic [17:0]      bar1,
  output logic [17:0]      bar2,
  output logic [17:0]      bar3,
  output logic [17:0]      bar4,
  output logic [17:0]      bar5,
  output logic [17:0]      bar6,
  output logic [17:0]      bar7,
  output logic [17:0]      bar8,
  output logic [17:0]      bar9,
  output logic [17:0]      bar10,
  output logic [17:0]      bar11,
  output logic [17:0]      bar12,
  output logic [17:0]      bar13,
  output logic [17:0]      bar14,
  output logic [17:0]      bar15,
  output logic             frame_tick
);
  localparam int DW = $clog2(DECAY_FRAMES + 1);
  typedef enum logic [1:0] {COLLECT, UPDATE, COMMIT} state_t;
  state_t state, state_next;
  logic [3:0] idx;
  logic vs1, vs2, vs3, fall;
  logic [MAG_W-1:0] shifted;
  logic [4:0] level;
  logic [4:0] pending [16];
  logic [4:0] held [16];
  logic [17:0] bars [16];
  logic [DW-1:0] decay_cnt;
  logic decay_due, ready_next;

  function automatic logic [17:0] mask(input logic [4:0] l);
    return 18'((19'd1 << l) - 19'd1);
  endfunction

  always_comb begin
    shifted = mag_data >> SHIFT;
    level = shifted > MAG_W'(18) ? 5'd18 : shifted[4:0];
    fall = vs3 & ~vs2;
    decay_due = decay_cnt == DW'(DECAY_FRAMES - 1);
  end

  always_ff @(posedge clk)
    if (rst) state <= COLLECT;
    else state <= state_next;

  always_comb begin
    state_next = (state == COLLECT && fall) ? UPDATE :
                 (state == UPDATE && idx == 4'd15) ? COMMIT :
                 (state == COMMIT) ? COLLECT : state;
  end

  always_comb ready_next = state_next == COLLECT;

  // decay_cnt only moves in COMMIT, so decay_due is stable across all of UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      vs1 <= 1'b1;
      vs2 <= 1'b1;
      vs3 <= 1'b1;
      idx <= '0;
      decay_cnt <= '0;
      mag_ready <= 1'b0;
      frame_tick <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        pending[i] <= '0;
        held[i] <= '0;
        bars[i] <= '0;
      end
    end else begin
      vs1 <= vsync;
      vs2 <= vs1;
      vs3 <= vs2;
      mag_ready <= ready_next;
      frame_tick <= state == COMMIT;
      if (mag_valid && mag_ready && level > pending[mag_bin]) pending[mag_bin] <= level;
      if (state == UPDATE) begin
        idx <= idx + 4'd1;
        pending[idx] <= '0;
        held[idx] <= pending[idx] >= held[idx] ? pending[idx] :
                     (decay_due && held[idx] != 5'd0) ? held[idx] - 5'd1 : held[idx];
      end
      if (state == COMMIT) begin
        for (int i = 0; i < 16; i++) bars[i] <= mask(held[i]);
        decay_cnt <= decay_due ? '0 : decay_cnt + 1'b1;
      end
    end
  end

  assign bar0  = bars[0];
  assign bar1  = bars[1];
  assign bar2  = bars[2];
  assign bar3  = bars[3];
  assign bar4  = bars[4];
  assign bar5  = bars[5];
  assign bar6  = bars[6];
  assign bar7  = bars[7];
  assign bar8  = bars[8];
  assign bar9  = bars[9];
  assign bar10 = bars[10];
  assign bar11 = bars[11];
  assign bar12 = bars[12];
  assign bar13 = bars[13];
  assign bar14 = bars[14];
  assign bar15 = bars[15];
endmodule

// File: doc/spectrum_bar_encoder.md
# spectrum_bar_encoder

Producer side of the bar-graph display path. Accepts per-bin spectrum magnitudes over a valid/ready stream and quantizes each to an 18-segment level. Applies peak-hold with frame-based decay, then presents the 16 bar masks consumed by the `vga` display. Bar outputs change only once per video frame, at the vsync falling edge, so the display never draws a half-updated spectrum.

## Interface
- `MAG_W`, 16, magnitude width.
- `SHIFT`, 11, right shift applied to a magnitude to form its level.
- `DECAY_FRAMES`, 4, frames between one-segment decrements of a held level (≥1).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mag_valid`  in  1  magnitude beat valid.
- `mag_ready`  out  1  block accepts a beat; transfer occurs on `mag_valid && mag_ready` at a `clk` edge.
- `mag_bin`  in  4  bin index 0–15.
- `mag_data`  in  MAG_W  unsigned magnitude.
- `vsync`  in  1  active-low vertical sync from the display, asynchronous to `clk`.
- `bar0` … `bar15`  out  18 each  thermometer mask; bit 0 is the bottom segment.
- `frame_tick`  out  1  one-cycle pulse in the cycle the bars update.

## Operation
- Level: `level = min(18, mag_data >> SHIFT)`, 5 bits. Mask: `(1<<level)-1`, so level 18 gives 0x3FFFF and level 0 gives 0x00000.
- Per-bin state:
  - `pending[16]` (5 b) holds the peak level received this frame.
  - `held[16]` (5 b) holds the displayed level.
  - `decay_cnt` counts 0..DECAY_FRAMES-1.
- `vsync` passes through a 2-FF synchronizer, then an edge register. All three flops reset to 1, so reset never produces a spurious edge. A frame boundary is a falling edge on the synchronized signal.
- FSM:
  - COLLECT: `mag_ready`=1. Each accepted beat sets `pending[mag_bin] = max(pending[mag_bin], level)`. On a frame-boundary detect, go to UPDATE. A beat accepted on the same edge as that transition counts for the closing frame.
  - UPDATE: 16 cycles, bin i processed in cycle i, `mag_ready`=0.
    - If `pending[i] >= held[i]`, then `held[i] = pending[i]`.
    - Otherwise, if `decay_due && held[i]>0`, then `held[i]` is decremented by 1.
    - Otherwise `held[i]` is unchanged.
    - In every case `pending[i]` is cleared to 0.
    - `decay_due = (decay_cnt == DECAY_FRAMES-1)`, evaluated once at UPDATE entry.
  - COMMIT: 1 cycle, `mag_ready`=0. All 16 `bar` registers load the masks of `held` simultaneously. `frame_tick` is set and `decay_cnt` advances, wrapping to 0 after DECAY_FRAMES-1. Then go to COLLECT.
- Frame-boundary edges arriving during UPDATE or COMMIT are ignored. Frames are far longer than 17 cycles.
- `mag_valid` held while `mag_ready`=0 is not consumed. The producer holds the beat, and it is accepted in COLLECT and counted in the next frame.
- Reset values:
  - all `bar` = 0, `frame_tick` = 0, `mag_ready` = 0 while `rst` is high;
  - `pending`, `held` and `decay_cnt` = 0;
  - state = COLLECT.
- Reset mid-UPDATE or mid-COMMIT aborts the update and clears everything. Bars read 0 until the next completed frame.

## Timing
- Let edge 1 be the first `clk` edge sampling `vsync` low.
  - The edge is detected between edges 2 and 3; a beat accepted at edge 3 belongs to the old frame.
  - At edge 3 the FSM enters UPDATE. Bin i is processed at edge 4+i (edges 4–19).
  - At edge 20 (COMMIT) the bars change and `frame_tick` rises, high for exactly one cycle.
- `mag_ready` is low from after edge 3 until after edge 20: 17 cycles of backpressure per frame.
- Input-to-display latency: a beat is visible at the first COMMIT following the frame boundary that closes its frame.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `mag_ready` is 1 in the first cycle after `rst` deasserts.

## Test plan
- Reset: hold `rst` for 3 cycles, then check that all bars are 0x00000, `frame_tick`=0 and `mag_ready`=0, with `mag_ready`=1 on the next cycle.
- Full frame: send bin i with `mag_data = i<<11` (i=0..15), then pull `vsync` low.
  - Expect `bar_i = (1<<i)-1`, e.g. `bar15`=0x07FFF and `bar0`=0.
  - Expect `frame_tick` to pulse once at edge 20 after vsync is sampled low.
- Clip and floor: bin 7 with 0xFFFF gives `bar7`=0x3FFFF. Bin 3 with 0x07FF gives `bar3`=0x00000.
- Intra-frame peak: bin 2 receives 0x2000 then 0x0800 in one frame; expect `bar2`=0x0000F.
- Decay (DECAY_FRAMES=4) on bin 5:
  - Send bin 5 = 0x5000 (level 10) in frame 1 only; `bar5`=0x003FF after frames 1–3.
  - `bar5`=0x001FF after frame 4 and 0x000FF after frame 8.
  - A new level-12 beat in frame 9 gives 0x00FFF immediately.
- Backpressure and reset:
  - Hold `mag_valid` with bin 1 = 0x3000 through UPDATE. It must stay unconsumed until `mag_ready` returns, then appear in the following frame as 0x0003F.
  - Assert `rst` at UPDATE cycle 5; all bars must read 0 and the FSM must resume COLLECT.
